// File: rtl/maxi_initiator_pkg.sv
// Shared widths and FSM state encodings for the AXI initiator bridge.
// The read and write paths each keep their own state type.
package maxi_initiator_pkg;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 12;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/maxi_beat_counter.sv
// Burst beat counter: loads a burst length, counts accepted beats and flags the final beat.
// It holds at the final beat, so the count never wraps inside a burst.
module maxi_beat_counter
    import maxi_initiator_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_s,
    input  logic [LEN_W-1:0] len_in_s,
    input  logic             incr_s,
    output logic [LEN_W-1:0] count_r,
    output logic [LEN_W-1:0] len_r,
    output logic             last_s
);

    // Count register and latched burst length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {LEN_W{1'b0}};
            len_r   <= {LEN_W{1'b0}};
        end else if (load_s) begin
            count_r <= {LEN_W{1'b0}};
            len_r   <= len_in_s;
        end else if (incr_s && !last_s) begin
            count_r <= count_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign last_s = (count_r == len_r);

endmodule

// File: rtl/maxi_initiator.sv
// User-side request/beat streams bridged onto an AXI-style ENA/RDY client port.
// Independent read and write FSMs; protoErr latches response-side inconsistencies.
module maxi_initiator
    import maxi_initiator_pkg::*;
#(
    parameter logic [ID_W-1:0] ID = 12'd0
) (
    input  logic              CLK,
    input  logic              nRST,
    // user read side
    input  logic              rdReq__ENA,
    output logic              rdReq__RDY,
    input  logic [ADDR_W-1:0] rdReq_addr,
    input  logic [LEN_W-1:0]  rdReq_len,
    output logic              rdData__ENA,
    input  logic              rdData__RDY,
    output logic [DATA_W-1:0] rdData_data,
    output logic [RESP_W-1:0] rdData_resp,
    output logic              rdData_last,
    // user write side
    input  logic              wrReq__ENA,
    output logic              wrReq__RDY,
    input  logic [ADDR_W-1:0] wrReq_addr,
    input  logic [LEN_W-1:0]  wrReq_len,
    input  logic              wrData__ENA,
    output logic              wrData__RDY,
    input  logic [DATA_W-1:0] wrData_data,
    output logic              wrDone__ENA,
    input  logic              wrDone__RDY,
    output logic [RESP_W-1:0] wrDone_resp,
    output logic              protoErr,
    // AXI client side
    output logic              AR__ENA,
    input  logic              AR__RDY,
    output logic [ADDR_W-1:0] AR_addr,
    output logic [ID_W-1:0]   AR_id,
    output logic [LEN_W-1:0]  AR_len,
    output logic              AW__ENA,
    input  logic              AW__RDY,
    output logic [ADDR_W-1:0] AW_addr,
    output logic [ID_W-1:0]   AW_id,
    output logic [LEN_W-1:0]  AW_len,
    output logic              W__ENA,
    input  logic              W__RDY,
    output logic [DATA_W-1:0] W_data,
    output logic [ID_W-1:0]   W_id,
    output logic              W_last,
    input  logic              R__ENA,
    output logic              R__RDY,
    input  logic [DATA_W-1:0] R_data,
    input  logic [ID_W-1:0]   R_id,
    input  logic              R_last,
    input  logic [RESP_W-1:0] R_resp,
    input  logic              B__ENA,
    output logic              B__RDY,
    input  logic [ID_W-1:0]   B_id,
    input  logic [RESP_W-1:0] B_resp
);

    rd_state_e         rd_state_r;
    wr_state_e         wr_state_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              proto_err_r;

    logic              rd_req_xfer_s;
    logic              wr_req_xfer_s;
    logic              ar_xfer_s;
    logic              aw_xfer_s;
    logic              r_xfer_s;
    logic              w_xfer_s;
    logic              b_xfer_s;

    logic [LEN_W-1:0]  rd_count_s;
    logic [LEN_W-1:0]  rd_len_s;
    logic              rd_last_s;
    logic [LEN_W-1:0]  wr_count_s;
    logic [LEN_W-1:0]  wr_len_s;
    logic              wr_last_s;

    // Handshake qualification: every ENA output is gated by its partner RDY.
    assign rd_req_xfer_s = rdReq__ENA && (rd_state_r == R_IDLE);
    assign wr_req_xfer_s = wrReq__ENA && (wr_state_r == W_IDLE);
    assign ar_xfer_s     = (rd_state_r == R_ADDR) && AR__RDY;
    assign aw_xfer_s     = (wr_state_r == W_ADDR) && AW__RDY;
    assign r_xfer_s      = (rd_state_r == R_DATA) && rdData__RDY && R__ENA;
    assign w_xfer_s      = (wr_state_r == W_DATA) && W__RDY && wrData__ENA;
    assign b_xfer_s      = (wr_state_r == W_RESP) && wrDone__RDY && B__ENA;

    maxi_beat_counter u_rd_cnt (
        .clk      (CLK),
        .rst_n    (nRST),
        .load_s   (rd_req_xfer_s),
        .len_in_s (rdReq_len),
        .incr_s   (r_xfer_s),
        .count_r  (rd_count_s),
        .len_r    (rd_len_s),
        .last_s   (rd_last_s)
    );

    maxi_beat_counter u_wr_cnt (
        .clk      (CLK),
        .rst_n    (nRST),
        .load_s   (wr_req_xfer_s),
        .len_in_s (wrReq_len),
        .incr_s   (w_xfer_s),
        .count_r  (wr_count_s),
        .len_r    (wr_len_s),
        .last_s   (wr_last_s)
    );

    // Read FSM: request latch, AR issue, then beat streaming until the final beat.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_state_r <= R_IDLE;
            rd_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (rd_req_xfer_s) begin
                        rd_addr_r  <= rdReq_addr;
                        rd_state_r <= R_ADDR;
                    end else begin
                        rd_state_r <= R_IDLE;
                    end
                end
                R_ADDR: begin
                    if (ar_xfer_s) begin
                        rd_state_r <= R_DATA;
                    end else begin
                        rd_state_r <= R_ADDR;
                    end
                end
                R_DATA: begin
                    if (r_xfer_s && rd_last_s) begin
                        rd_state_r <= R_IDLE;
                    end else begin
                        rd_state_r <= R_DATA;
                    end
                end
                default: rd_state_r <= R_IDLE;
            endcase
        end
    end

    // Write FSM: request latch, AW issue, data beats, then wait for the B response.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_state_r <= W_IDLE;
            wr_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (wr_req_xfer_s) begin
                        wr_addr_r  <= wrReq_addr;
                        wr_state_r <= W_ADDR;
                    end else begin
                        wr_state_r <= W_IDLE;
                    end
                end
                W_ADDR: begin
                    if (aw_xfer_s) begin
                        wr_state_r <= W_DATA;
                    end else begin
                        wr_state_r <= W_ADDR;
                    end
                end
                W_DATA: begin
                    if (w_xfer_s && wr_last_s) begin
                        wr_state_r <= W_RESP;
                    end else begin
                        wr_state_r <= W_DATA;
                    end
                end
                W_RESP: begin
                    if (b_xfer_s) begin
                        wr_state_r <= W_IDLE;
                    end else begin
                        wr_state_r <= W_RESP;
                    end
                end
                default: wr_state_r <= W_IDLE;
            endcase
        end
    end

    // Sticky protocol-error flag; only a reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            proto_err_r <= 1'b0;
        end else if ((r_xfer_s && ((R_last != rd_last_s) || (R_id != ID))) ||
                     (b_xfer_s && (B_id != ID))) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    assign protoErr    = proto_err_r;

    assign rdReq__RDY  = (rd_state_r == R_IDLE);
    assign AR__ENA     = ar_xfer_s;
    assign AR_addr     = rd_addr_r;
    assign AR_len      = rd_len_s;
    assign AR_id       = ID;
    assign R__RDY      = (rd_state_r == R_DATA) && rdData__RDY;
    assign rdData__ENA = r_xfer_s;
    assign rdData_data = R_data;
    assign rdData_resp = R_resp;
    assign rdData_last = rd_last_s;

    assign wrReq__RDY  = (wr_state_r == W_IDLE);
    assign AW__ENA     = aw_xfer_s;
    assign AW_addr     = wr_addr_r;
    assign AW_len      = wr_len_s;
    assign AW_id       = ID;
    assign wrData__RDY = (wr_state_r == W_DATA) && W__RDY;
    assign W__ENA      = w_xfer_s;
    assign W_data      = wrData_data;
    assign W_id        = ID;
    assign W_last      = wr_last_s;
    assign B__RDY      = (wr_state_r == W_RESP) && wrDone__RDY;
    assign wrDone__ENA = b_xfer_s;
    assign wrDone_resp = B_resp;

endmodule

// File: doc/maxi_initiator.md
MAXI_INITIATOR -- requirements
Module: maxi_initiator

Interface
REQ-001 SHALL have parameter ID, default 12'd0, meaning AXI ID driven on AR$id, AW$id and W$id.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
- CLK  in  1  sole clock; all state on rising edge.
- nRST  in  1  async assert, sync deassert, active-low.
REQ-003 SHALL have these user-side ports:
- rdReq__ENA / rdReq__RDY  in / out  1  read-request handshake.
- rdReq$addr / rdReq$len  in  32 / 4  read address; beats-1.
- rdData__ENA / rdData__RDY  out / in  1  read-beat handshake.
- rdData$data / rdData$resp / rdData$last  out  32 / 2 / 1  beat payload.
- wrReq__ENA / wrReq__RDY  in / out  1  write-request handshake.
- wrReq$addr / wrReq$len  in  32 / 4  write address; beats-1.
- wrData__ENA / wrData__RDY / wrData$data  in / out / in  1 / 1 / 32  write-beat stream.
- wrDone__ENA / wrDone__RDY / wrDone$resp  out / in / out  1 / 1 / 2  write completion.
- protoErr  out  1  sticky protocol-error flag.
REQ-004 SHALL have the AXI client side with the same field widths as the AXI slave interface:
- AR__ENA/$addr/$id/$len  out  1/32/12/4; AR__RDY  in.
- AW__ENA/$addr/$id/$len  out  1/32/12/4; AW__RDY  in.
- W__ENA/$data/$id/$last  out  1/32/12/1; W__RDY  in.
- R__ENA/$data/$id/$last/$resp  in  1/32/12/1/2; R__RDY  out.
- B__ENA/$id/$resp  in  1/12/2; B__RDY  out.

Function
REQ-005 SHALL treat a transfer as ENA high in a cycle; an ENA output is asserted only while the matching RDY is high.
REQ-006 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA; rdReq__RDY = (R_IDLE).
REQ-007 On rdReq transfer, the read FSM SHALL latch addr/len, clear the beat counter and go to R_ADDR; AR__ENA is asserted no earlier than the next cycle.
REQ-008 In R_ADDR: AR__ENA = AR__RDY with latched addr/len and ID; on transfer go to R_DATA.
REQ-009 In R_DATA: R__RDY = rdData__RDY; rdData__ENA = R__ENA; data/resp pass through combinationally; rdData$last = (count == len).
REQ-010 Each R beat SHALL increment the 4-bit counter; the beat with count == len returns the read FSM to R_IDLE.
REQ-011 The write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP; wrReq__RDY = (W_IDLE); wrReq is latched and AW issued as for the read path.
REQ-012 In W_DATA: wrData__RDY = W__RDY; W__ENA = wrData__ENA; W$last = (count == len); the last beat goes to W_RESP.
REQ-013 wrData__RDY SHALL be 0 outside W_DATA, so no W beat precedes its AW.
REQ-014 In W_RESP: B__RDY = wrDone__RDY; wrDone__ENA = B__ENA; wrDone$resp = B$resp; on transfer go to W_IDLE.
REQ-015 R__RDY and B__RDY SHALL be 0 outside R_DATA and W_RESP respectively; R/B beats arriving then are ignored.
REQ-016 Read and write FSMs SHALL be fully independent; both may be active in the same cycle.
REQ-017 protoErr SHALL set, and stay set until reset, on an accepted R beat with R$last != rdData$last or R$id != ID, or an accepted B with B$id != ID.
REQ-018 len = 15 SHALL give 16 beats; the counter never wraps within a burst.

Reset
REQ-019 While nRST = 0: both FSMs idle, counters 0, protoErr 0; all ENA outputs 0 and all RDY outputs 0 except rdReq__RDY = wrReq__RDY = 1.
REQ-020 Reset mid-burst SHALL abandon the burst with no further beats or completion.

Structure
REQ-021 The shared package SHALL hold the width constants ADDR_W=32, ID_W=12, LEN_W=4, DATA_W=32, RESP_W=2 and the read/write state enums.
REQ-022 The design SHALL use one sub-module, maxi_beat_counter (load/increment/last compare), instantiated for read and for write.

Verification
REQ-023 Read addr 0x100, len 3; slave returns 4 beats with last on beat 4 -> one AR (len 3, id 0), 4 rdData beats, last on the 4th, rdReq__RDY high again.
REQ-024 Write addr 0x200, len 1, data 0xA, 0xB -> AW, then W 0xA (last 0) and 0xB (last 1), then wrDone with resp 0 after B.
REQ-025 Concurrent read len 0 and write len 0 in the same cycle -> both complete independently; AR and AW may issue in the same cycle.
REQ-026 rdData__RDY held low for 5 cycles mid-burst -> R__RDY low for those cycles; no beat lost or duplicated.
REQ-027 R$last on beat 2 of a len-3 read -> protoErr = 1 and stays 1; reset mid-burst -> protoErr 0, both FSMs idle.
